// File: rtl/eca_pkg.sv
// eca_pkg
//   Types and constants shared by the cellular-automaton rule engine:
//     - eca_state_e : control FSM states (IDLE / RUN / DONE)
//     - eca_rule_w  : truth-table width for a given neighbourhood radius
//     - RULE_*      : named 3-cell rule words (radius 1)
package eca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eca_state_e;

  // A neighbourhood of 2*radius+1 cells addresses a 2**(2*radius+1) entry table.
  function automatic int eca_rule_w(input int radius);
    return 1 << (2 * radius + 1);
  endfunction

  localparam logic [7:0] RULE_90       = 8'h5A;
  localparam logic [7:0] RULE_IDENTITY = 8'hCC;
  localparam logic [7:0] RULE_ZERO     = 8'h00;

endpackage

// File: rtl/eca_next_gen.sv
// eca_next_gen
//   Purely combinational one-generation step of a 1-D cellular automaton.
//   Cell i looks up rule[idx] with idx = {c[i+RADIUS], ..., c[i], ..., c[i-RADIUS]},
//   i.e. the higher cell index forms the index MSB.
//   Ports:
//     state_i     : current cell vector
//     rule_i      : truth table (RULE_W bits)
//     wrap_mode_i : 1 = toroidal edges, 0 = cells beyond the edge read as 0
//     next_o      : next-generation cell vector
module eca_next_gen
  import eca_pkg::*;
#(
  parameter int N_CELLS = 16,
  parameter int RADIUS  = 1
) (
  input  logic [N_CELLS-1:0]            state_i,
  input  logic [eca_rule_w(RADIUS)-1:0] rule_i,
  input  logic                          wrap_mode_i,
  output logic [N_CELLS-1:0]            next_o
);

  localparam int NB_W = 2 * RADIUS + 1;

  // Per-cell neighbourhood index.
  logic [NB_W-1:0] idx_w [N_CELLS];

  genvar gi, gk;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_cell
      for (gk = 0; gk < NB_W; gk++) begin : g_nb
        // Bit gk of the index is cell gi+gk-RADIUS, so gk = NB_W-1 is the highest cell.
        localparam int J = gi + gk - RADIUS;
        if (J >= 0 && J < N_CELLS) begin : g_in
          assign idx_w[gi][gk] = state_i[J];
        end else begin : g_edge
          // N_CELLS >= NB_W keeps J within (-N_CELLS, 2*N_CELLS), so one fold suffices.
          localparam int JW = (J + N_CELLS) % N_CELLS;
          assign idx_w[gi][gk] = wrap_mode_i & state_i[JW];
        end
      end
      assign next_o[gi] = rule_i[idx_w[gi]];
    end
  endgenerate

endmodule

// File: rtl/eca_rule_engine.sv
// eca_rule_engine
//   Programmable 1-D cellular-automaton engine. Holds a rule word and an
//   N_CELLS state register, and on request advances the state one generation
//   per clock for steps_in generations, then pulses done.
//   Optional feature macro: ECA_FIXED_POINT_EN -- adds output fixed_point and
//   ends a run early on the first generation that leaves the state unchanged.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     rule_in / rule_wr    : rule write (IDLE only)
//     seed_in / seed_valid / seed_ready : seed handshake (accepted in IDLE)
//     wrap_mode            : edge behaviour, used every RUN cycle
//     steps_in / start     : run request (IDLE only)
//     busy, done           : RUN indicator, one-cycle end-of-run pulse
//     state_out            : cell register
//     step_count           : generations completed in current/last run
//     fixed_point          : (ECA_FIXED_POINT_EN) last run stopped on a fixed point
module eca_rule_engine
  import eca_pkg::*;
#(
  parameter int N_CELLS = 16,
  parameter int RADIUS  = 1,
  parameter int CNT_W   = 16,
  parameter logic [eca_rule_w(RADIUS)-1:0] DEFAULT_RULE = RULE_90
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [eca_rule_w(RADIUS)-1:0] rule_in,
  input  logic                          rule_wr,
  input  logic [N_CELLS-1:0]            seed_in,
  input  logic                          seed_valid,
  output logic                          seed_ready,
  input  logic                          wrap_mode,
  input  logic [CNT_W-1:0]              steps_in,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [N_CELLS-1:0]            state_out,
  output logic [CNT_W-1:0]              step_count
`ifdef ECA_FIXED_POINT_EN
  ,
  output logic                          fixed_point
`endif
);

  localparam int RULE_W = eca_rule_w(RADIUS);

  eca_state_e          fsm_q;
  logic [N_CELLS-1:0]  state_q;
  logic [RULE_W-1:0]   rule_q;
  logic [CNT_W-1:0]    step_q;
  logic [CNT_W-1:0]    rem_q;
  logic                busy_q;
  logic                done_q;
  logic                ready_q;
  logic [N_CELLS-1:0]  next_d;
  logic                fp_hit;

  eca_next_gen #(
    .N_CELLS (N_CELLS),
    .RADIUS  (RADIUS)
  ) u_next_gen (
    .state_i     (state_q),
    .rule_i      (rule_q),
    .wrap_mode_i (wrap_mode),
    .next_o      (next_d)
  );

`ifdef ECA_FIXED_POINT_EN
  logic fp_q;
  assign fp_hit      = (next_d == state_q);
  assign fixed_point = fp_q;
`else
  assign fp_hit = 1'b0;
`endif

  // Control FSM; busy/done/seed_ready are registered alongside the state so
  // they always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rule_q  <= DEFAULT_RULE;
      step_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef ECA_FIXED_POINT_EN
      fp_q    <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          // Seed, rule and start may coincide; the first RUN cycle then
          // already sees the new seed and rule.
          if (seed_valid) state_q <= seed_in;
          if (rule_wr)    rule_q  <= rule_in;
          if (start) begin
            step_q  <= '0;
            rem_q   <= steps_in;
            ready_q <= 1'b0;
`ifdef ECA_FIXED_POINT_EN
            fp_q    <= 1'b0;
`endif
            if (steps_in == '0) begin
              fsm_q  <= DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end

        RUN: begin
          state_q <= next_d;
          step_q  <= step_q + CNT_W'(1);
          rem_q   <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1) || fp_hit) begin
            fsm_q  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`ifdef ECA_FIXED_POINT_EN
            fp_q   <= fp_hit;
`endif
          end
        end

        DONE: begin
          fsm_q   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          fsm_q   <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign seed_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_out  = state_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_eca_rule_engine.sv
// tb_eca_rule_engine
//   Directed bench for eca_rule_engine at N_CELLS=8, RADIUS=1, CNT_W=16.
//   A vector table covers single runs; hand sequences cover ignored inputs
//   during RUN, identity-rule runs (fixed-point when ECA_FIXED_POINT_EN) and
//   reset in the middle of a run.
module tb_eca_rule_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rule_in;
  logic        rule_wr;
  logic [7:0]  seed_in;
  logic        seed_valid;
  logic        seed_ready;
  logic        wrap_mode;
  logic [15:0] steps_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  state_out;
  logic [15:0] step_count;
`ifdef ECA_FIXED_POINT_EN
  logic        fixed_point;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eca_rule_engine #(
    .N_CELLS      (8),
    .RADIUS       (1),
    .CNT_W        (16),
    .DEFAULT_RULE (8'h5A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rule_in    (rule_in),
    .rule_wr    (rule_wr),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .wrap_mode  (wrap_mode),
    .steps_in   (steps_in),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out),
    .step_count (step_count)
`ifdef ECA_FIXED_POINT_EN
    ,
    .fixed_point (fixed_point)
`endif
  );

  typedef struct {
    logic [7:0]  rule;
    logic        wr;
    logic [7:0]  seed;
    logic        wrap;
    logic [15:0] steps;
    logic [7:0]  exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Offer seed/rule/start together at one negedge, release them, then wait
  // for done. lat counts negedges after the start edge until done is seen.
  task automatic run_job(input logic [7:0] r, input logic wr, input logic [7:0] s,
                         input logic w, input logic [15:0] st,
                         output int lat, output logic busy_seen, output logic to);
    @(negedge clk);
    rule_in = r; rule_wr = wr; seed_in = s; seed_valid = 1'b1;
    wrap_mode = w; steps_in = st; start = 1'b1;
    @(negedge clk);
    rule_wr = 1'b0; seed_valid = 1'b0; start = 1'b0;
    lat = 1; busy_seen = busy; to = 1'b0;
    while (done !== 1'b1) begin
      if (lat >= 200) begin to = 1'b1; break; end
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
  endtask

  initial begin
    int lat;
    logic bs, to, done_seen;

    vecs[0] = '{8'h5A, 1'b0, 8'h10, 1'b1, 16'd1, 8'h28, 16'd1}; // default rule
    vecs[1] = '{8'h5A, 1'b1, 8'h80, 1'b1, 16'd1, 8'h41, 16'd1};
    vecs[2] = '{8'h5A, 1'b1, 8'h80, 1'b0, 16'd1, 8'h40, 16'd1};
    vecs[3] = '{8'h00, 1'b1, 8'hFF, 1'b0, 16'd2, 8'h00, 16'd2};
    vecs[4] = '{8'h5A, 1'b1, 8'h01, 1'b0, 16'd2, 8'h05, 16'd2};
    vecs[5] = '{8'h5A, 1'b1, 8'h01, 1'b1, 16'd3, 8'hAA, 16'd3};
    vecs[6] = '{8'hF0, 1'b1, 8'h04, 1'b0, 16'd1, 8'h02, 16'd1}; // next[i]=c[i+1]
    vecs[7] = '{8'hF0, 1'b1, 8'h01, 1'b1, 16'd1, 8'h80, 16'd1};
    vecs[8] = '{8'hFE, 1'b1, 8'h08, 1'b0, 16'd2, 8'h3E, 16'd2};
    vecs[9] = '{8'h5A, 1'b1, 8'h3C, 1'b1, 16'd0, 8'h3C, 16'd0}; // zero steps

    rst = 1'b1; rule_in = '0; rule_wr = 1'b0; seed_in = '0; seed_valid = 1'b0;
    wrap_mode = 1'b0; steps_in = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(state_out), 32'h0);
    check("reset_count", 32'(step_count), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ready", 32'(seed_ready), 32'h1);
`ifdef ECA_FIXED_POINT_EN
    check("reset_fp", 32'(fixed_point), 32'h0);
`endif

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i].rule, vecs[i].wr, vecs[i].seed, vecs[i].wrap, vecs[i].steps, lat, bs, to);
      $display("vec %0d: rule=%02h seed=%02h wrap=%0d steps=%0d -> state=%02h count=%0d lat=%0d",
               i, vecs[i].rule, vecs[i].seed, vecs[i].wrap, vecs[i].steps, state_out, step_count, lat);
      check("vec_timeout", 32'(to), 32'h0);
      check("vec_state", 32'(state_out), 32'(vecs[i].exp_state));
      check("vec_count", 32'(step_count), 32'(vecs[i].exp_cnt));
      check("vec_latency", 32'(lat), 32'(vecs[i].steps) + 32'd1);
      check("vec_ready_in_done", 32'(seed_ready), 32'h0);
      if (vecs[i].steps == 16'd0) check("vec_busy_never", 32'(bs), 32'h0);
      @(negedge clk);
      check("vec_done_pulse", 32'(done), 32'h0);
      check("vec_ready_after", 32'(seed_ready), 32'h1);
      check("vec_count_hold", 32'(step_count), 32'(vecs[i].exp_cnt));
    end

    // Rule write, seed and start offered during RUN must all be dropped.
    @(negedge clk);
    rule_in = 8'h5A; rule_wr = 1'b1; seed_in = 8'h10; seed_valid = 1'b1;
    wrap_mode = 1'b0; steps_in = 16'd5; start = 1'b1;
    @(negedge clk);
    rule_wr = 1'b0; seed_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check("run_busy", 32'(busy), 32'h1);
    check("run_ready", 32'(seed_ready), 32'h0);
    rule_in = 8'h00; rule_wr = 1'b1; seed_in = 8'hFF; seed_valid = 1'b1;
    steps_in = 16'd1; start = 1'b1;
    @(negedge clk);
    rule_wr = 1'b0; seed_valid = 1'b0; start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    $display("ignore-during-run: state=%02h count=%0d", state_out, step_count);
    check("ign_timeout", 32'(done), 32'h1);
    check("ign_state", 32'(state_out), 32'h02);
    check("ign_count", 32'(step_count), 32'd5);
    repeat (2) @(negedge clk);
    check("ign_no_queued_start", 32'(busy), 32'h0);
    check("ign_no_queued_done", 32'(done), 32'h0);

    // Identity rule: unchanged every generation.
`ifdef ECA_FIXED_POINT_EN
    run_job(8'hCC, 1'b1, 8'hA5, 1'b0, 16'd10, lat, bs, to);
    $display("identity: state=%02h count=%0d lat=%0d fp=%0d", state_out, step_count, lat, fixed_point);
    check("id_timeout", 32'(to), 32'h0);
    check("id_latency", 32'(lat), 32'd2);
    check("id_count", 32'(step_count), 32'd1);
    check("id_state", 32'(state_out), 32'hA5);
    check("id_fp", 32'(fixed_point), 32'h1);
`else
    run_job(8'hCC, 1'b1, 8'hA5, 1'b0, 16'd10, lat, bs, to);
    $display("identity: state=%02h count=%0d lat=%0d", state_out, step_count, lat);
    check("id_timeout", 32'(to), 32'h0);
    check("id_latency", 32'(lat), 32'd11);
    check("id_count", 32'(step_count), 32'd10);
    check("id_state", 32'(state_out), 32'hA5);
`endif

    // Reset in the middle of a 10-step run: abort with no done pulse.
    @(negedge clk);
    rule_in = 8'h5A; rule_wr = 1'b1; seed_in = 8'h10; seed_valid = 1'b1;
    wrap_mode = 1'b1; steps_in = 16'd10; start = 1'b1;
    @(negedge clk);
    rule_wr = 1'b0; seed_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ready", 32'(seed_ready), 32'h1);
    check("mid_rst_count", 32'(step_count), 32'h0);
    check("mid_rst_state", 32'(state_out), 32'h0);
`ifdef ECA_FIXED_POINT_EN
    check("mid_rst_fp", 32'(fixed_point), 32'h0);
`endif
    done_seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    $display("mid-run reset: state=%02h count=%0d", state_out, step_count);
    check("mid_rst_no_done", 32'(done_seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
